// File: rtl/seven_stage_fetch_receive_pkg.sv
// Shared definitions for the seven-stage core front end: the NOP encoding
// and default widths used by fetch-receive, decode and the stall unit.
package seven_stage_fetch_receive_pkg;

  localparam int DATA_WIDTH_DEF      = 32;
  localparam int ADDRESS_BITS_DEF    = 32;
  localparam int MAX_OUTSTANDING_DEF = 2;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  // Selects what the fetch-receive output register loads on the next edge.
  typedef enum logic [1:0] {
    SRC_KEEP = 2'd0,  // stalled: hold current contents
    SRC_IDLE = 2'd1,  // nothing available, or flushed: NOP / invalid
    SRC_HOLD = 2'd2,  // oldest buffered response
    SRC_RESP = 2'd3   // response arriving this cycle
  } out_src_e;

  // Occupancy counters need one extra bit so "full" is distinguishable from "empty".
  function automatic int count_bits(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_receive_fifo.sv
// Small synchronous FIFO used for the in-flight PC queue and the stalled
// response hold queue. With KILL_EN set, kill_all marks every stored entry
// dead by setting its MSB; an entry pushed on the same edge stays live.
module fetch_receive_fifo #(
  parameter int WIDTH   = 33,
  parameter int DEPTH   = 2,
  parameter bit KILL_EN = 1'b0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     kill_all,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full queue is only accepted when the head leaves on the same edge.
  always_comb begin
    empty     = (count == '0);
    full      = (count == CW'(DEPTH));
    do_pop    = pop && !empty;
    do_push   = push && (!full || do_pop);
    head_data = mem[rd_ptr];
  end

  // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (KILL_EN && kill_all) begin
        for (int i = 0; i < DEPTH; i++) mem[i][WIDTH-1] <= 1'b1;
      end
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifndef SYNTHESIS
  // Simulation-only reporting of protocol violations by the producer/consumer.
  always @(posedge clock) begin
    if (reset && !clear) begin
      if (push && full && !pop)
        $display("ERROR %m @%0t: push while full with no pop", $time);
      if (pop && empty)
        $display("ERROR %m @%0t: pop while empty", $time);
    end
  end
`endif

endmodule

// File: rtl/seven_stage_fetch_receive.sv
// Fetch-receive stage: matches in-order I-mem responses to their PCs, drops
// responses for flushed requests, buffers responses while decode is stalled,
// and reports issue/receive hazards to the stall unit.
module seven_stage_fetch_receive
  import seven_stage_fetch_receive_pkg::*;
#(
  parameter int                    CORE            = 0,
  parameter int                    DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int                    ADDRESS_BITS    = ADDRESS_BITS_DEF,
  parameter logic [DATA_WIDTH-1:0] NOP             = NOP_INSTR,
  parameter int                    MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
  parameter int                    SCAN_CYCLES_MIN = 0,
  parameter int                    SCAN_CYCLES_MAX = 1000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    issue_valid,
  input  logic [ADDRESS_BITS-1:0] issue_PC,
  input  logic                    i_mem_valid,
  input  logic [DATA_WIDTH-1:0]   i_mem_data,
  input  logic                    stall_fetch_receive,
  input  logic                    flush_fetch_receive,
  output logic [DATA_WIDTH-1:0]   instruction,
  output logic [ADDRESS_BITS-1:0] inst_PC,
  output logic                    inst_valid,
  output logic                    i_mem_issue_hazard,
  output logic                    i_mem_recv_hazard,
  input  logic                    scan
);

  localparam int CW = count_bits(MAX_OUTSTANDING);
  localparam int PQ_W = ADDRESS_BITS + 1;
  localparam int HQ_W = DATA_WIDTH + ADDRESS_BITS;

  logic [PQ_W-1:0]         pc_head;
  logic [CW-1:0]           pc_count;
  logic                    pc_empty;
  logic                    pc_full;
  logic                    pc_head_killed;
  logic [ADDRESS_BITS-1:0] pc_head_addr;

  logic [HQ_W-1:0]         hold_head;
  logic [CW-1:0]           hold_count;
  logic                    hold_empty;
  logic                    hold_full;
  logic                    hold_push;
  logic                    hold_pop;

  logic                    resp_live;
  logic [CW:0]             credits_used;
  out_src_e                out_src;

  logic signed [31:0]      cycle_count;

  fetch_receive_fifo #(
    .WIDTH   (PQ_W),
    .DEPTH   (MAX_OUTSTANDING),
    .KILL_EN (1'b1)
  ) u_pc_queue (
    .clock     (clock),
    .reset     (reset),
    .clear     (1'b0),
    .kill_all  (flush_fetch_receive),
    .push      (issue_valid),
    .push_data ({1'b0, issue_PC}),
    .pop       (i_mem_valid),
    .head_data (pc_head),
    .count     (pc_count),
    .empty     (pc_empty),
    .full      (pc_full)
  );

  fetch_receive_fifo #(
    .WIDTH   (HQ_W),
    .DEPTH   (MAX_OUTSTANDING),
    .KILL_EN (1'b0)
  ) u_hold_queue (
    .clock     (clock),
    .reset     (reset),
    .clear     (flush_fetch_receive),
    .kill_all  (1'b0),
    .push      (hold_push),
    .push_data ({i_mem_data, pc_head_addr}),
    .pop       (hold_pop),
    .head_data (hold_head),
    .count     (hold_count),
    .empty     (hold_empty),
    .full      (hold_full)
  );

  // Response classification, hold-queue routing, hazards and output source select.
  always_comb begin
    pc_head_killed = pc_head[ADDRESS_BITS];
    pc_head_addr   = pc_head[ADDRESS_BITS-1:0];

    // A response popped in the flush cycle belongs to the old path and is dropped.
    resp_live = i_mem_valid && !pc_empty && !pc_head_killed && !flush_fetch_receive;

    // Once anything is buffered, later responses must queue behind it to keep order.
    hold_push = resp_live && (stall_fetch_receive || !hold_empty);
    hold_pop  = !flush_fetch_receive && !stall_fetch_receive && !hold_empty;

    credits_used       = {1'b0, pc_count} + {1'b0, hold_count};
    i_mem_issue_hazard = (credits_used >= (CW+1)'(MAX_OUTSTANDING));
    i_mem_recv_hazard  = !pc_empty && !pc_head_killed && !i_mem_valid && hold_empty;

    out_src = SRC_IDLE;
    if (flush_fetch_receive)      out_src = SRC_IDLE;
    else if (stall_fetch_receive) out_src = SRC_KEEP;
    else if (!hold_empty)         out_src = SRC_HOLD;
    else if (resp_live)           out_src = SRC_RESP;
  end

  // Output register to decode.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      instruction <= NOP;
      inst_PC     <= '0;
      inst_valid  <= 1'b0;
    end else begin
      case (out_src)
        SRC_KEEP: ;
        SRC_HOLD: begin
          instruction <= hold_head[HQ_W-1:ADDRESS_BITS];
          inst_PC     <= hold_head[ADDRESS_BITS-1:0];
          inst_valid  <= 1'b1;
        end
        SRC_RESP: begin
          instruction <= i_mem_data;
          inst_PC     <= pc_head_addr;
          inst_valid  <= 1'b1;
        end
        default: begin
          instruction <= NOP;
          inst_PC     <= '0;
          inst_valid  <= 1'b0;
        end
      endcase
    end
  end

  // Free-running cycle counter for the debug scan window.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cycle_count <= '0;
    else        cycle_count <= cycle_count + 32'sd1;
  end

`ifndef SYNTHESIS
  // Debug trace of the stage outputs and queue occupancy inside the scan window.
  always @(posedge clock) begin
    if (reset && scan && (cycle_count >= SCAN_CYCLES_MIN) && (cycle_count <= SCAN_CYCLES_MAX)) begin
      $display("[core %0d fetch_receive cyc %0d] inst=%h pc=%h valid=%b issue_hz=%b recv_hz=%b pcq=%0d%s holdq=%0d%s",
               CORE, cycle_count, instruction, inst_PC, inst_valid,
               i_mem_issue_hazard, i_mem_recv_hazard,
               pc_count, pc_full ? "(full)" : "", hold_count, hold_full ? "(full)" : "");
    end
  end
`endif

endmodule

// File: tb/tb_seven_stage_fetch_receive.sv
// Directed bench for seven_stage_fetch_receive: a table of per-cycle vectors
// (hazards checked before the edge, outputs and queue counts after it) plus
// hand-written reset sequences.
module tb_seven_stage_fetch_receive;

  localparam logic [31:0] NOP_V = 32'h00000013;

  logic        clock;
  logic        reset;
  logic        issue_valid;
  logic [31:0] issue_PC;
  logic        i_mem_valid;
  logic [31:0] i_mem_data;
  logic        stall_fetch_receive;
  logic        flush_fetch_receive;
  logic [31:0] instruction;
  logic [31:0] inst_PC;
  logic        inst_valid;
  logic        i_mem_issue_hazard;
  logic        i_mem_recv_hazard;
  logic        scan;

  int n_checks = 0;
  int n_fail   = 0;

  seven_stage_fetch_receive dut (
    .clock               (clock),
    .reset               (reset),
    .issue_valid         (issue_valid),
    .issue_PC            (issue_PC),
    .i_mem_valid         (i_mem_valid),
    .i_mem_data          (i_mem_data),
    .stall_fetch_receive (stall_fetch_receive),
    .flush_fetch_receive (flush_fetch_receive),
    .instruction         (instruction),
    .inst_PC             (inst_PC),
    .inst_valid          (inst_valid),
    .i_mem_issue_hazard  (i_mem_issue_hazard),
    .i_mem_recv_hazard   (i_mem_recv_hazard),
    .scan                (scan)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        iv;
    logic [31:0] ipc;
    logic        mv;
    logic [31:0] md;
    logic        st;
    logic        fl;
    logic        e_ih;
    logic        e_rh;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
    logic        e_v;
    int          e_pcc;
    int          e_hc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic iv, input logic [31:0] ipc, input logic mv, input logic [31:0] md,
                     input logic st, input logic fl, input logic e_ih, input logic e_rh,
                     input logic [31:0] e_inst, input logic [31:0] e_pc, input logic e_v,
                     input int e_pcc, input int e_hc);
    vec_t v;
    v.iv = iv; v.ipc = ipc; v.mv = mv; v.md = md; v.st = st; v.fl = fl;
    v.e_ih = e_ih; v.e_rh = e_rh; v.e_inst = e_inst; v.e_pc = e_pc; v.e_v = e_v;
    v.e_pcc = e_pcc; v.e_hc = e_hc;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic iv, input logic [31:0] ipc, input logic mv, input logic [31:0] md,
                       input logic st, input logic fl);
    @(negedge clock);
    issue_valid = iv; issue_PC = ipc; i_mem_valid = mv; i_mem_data = md;
    stall_fetch_receive = st; flush_fetch_receive = fl;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] e_inst, input logic [31:0] e_pc, input logic e_v);
    chk({tag, " instruction"}, instruction, e_inst);
    chk({tag, " inst_PC"}, inst_PC, e_pc);
    chk({tag, " inst_valid"}, inst_valid, e_v);
  endtask

  initial begin
    reset = 1'b0;
    issue_valid = 0; issue_PC = 0; i_mem_valid = 0; i_mem_data = 0;
    stall_fetch_receive = 0; flush_fetch_receive = 0; scan = 0;

    //  iv ipc          mv md            st fl  ih rh  inst          pc         v  pcc hc
    add(1, 32'h100,     0, 0,            0, 0,  0, 0,  NOP_V,        0,         0, 1,  0);
    add(0, 0,           0, 0,            0, 0,  0, 1,  NOP_V,        0,         0, 1,  0);
    add(1, 32'h100,     1, 32'h00500093, 0, 0,  0, 0,  32'h00500093, 32'h100,   1, 1,  0);
    add(1, 32'h104,     0, 0,            1, 0,  0, 1,  32'h00500093, 32'h100,   1, 2,  0);
    add(0, 0,           1, 32'h11111111, 1, 0,  1, 0,  32'h00500093, 32'h100,   1, 1,  1);
    add(0, 0,           1, 32'h22222222, 1, 0,  1, 0,  32'h00500093, 32'h100,   1, 0,  2);
    add(0, 0,           0, 0,            1, 0,  1, 0,  32'h00500093, 32'h100,   1, 0,  2);
    add(0, 0,           0, 0,            0, 0,  1, 0,  32'h11111111, 32'h100,   1, 0,  1);
    add(0, 0,           0, 0,            0, 0,  0, 0,  32'h22222222, 32'h104,   1, 0,  0);
    add(0, 0,           0, 0,            0, 0,  0, 0,  NOP_V,        0,         0, 0,  0);
    add(1, 32'h200,     0, 0,            0, 0,  0, 0,  NOP_V,        0,         0, 1,  0);
    add(1, 32'h300,     0, 0,            0, 1,  0, 1,  NOP_V,        0,         0, 2,  0);
    add(0, 0,           0, 0,            0, 0,  1, 0,  NOP_V,        0,         0, 2,  0);
    add(0, 0,           1, 32'hAAAAAAAA, 0, 0,  1, 0,  NOP_V,        0,         0, 1,  0);
    add(0, 0,           0, 0,            0, 0,  0, 1,  NOP_V,        0,         0, 1,  0);
    add(0, 0,           1, 32'hBBBBBBBB, 0, 0,  0, 0,  32'hBBBBBBBB, 32'h300,   1, 0,  0);
    add(0, 0,           0, 0,            1, 1,  0, 0,  NOP_V,        0,         0, 0,  0);
    add(1, 32'h400,     0, 0,            0, 0,  0, 0,  NOP_V,        0,         0, 1,  0);
    add(1, 32'h404,     0, 0,            0, 0,  0, 1,  NOP_V,        0,         0, 2,  0);
    add(1, 32'h408,     1, 32'h44444444, 0, 0,  1, 0,  32'h44444444, 32'h400,   1, 2,  0);
    add(0, 0,           1, 32'h48484848, 0, 0,  1, 0,  32'h48484848, 32'h404,   1, 1,  0);
    add(0, 0,           1, 32'h4C4C4C4C, 0, 0,  0, 0,  32'h4C4C4C4C, 32'h408,   1, 0,  0);

    // Reset state, while asserted and after synchronous release.
    repeat (2) @(negedge clock);
    chk_out("in_reset", NOP_V, 0, 1'b0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk_out("after_reset", NOP_V, 0, 1'b0);
    chk("after_reset issue_hazard", i_mem_issue_hazard, 1'b0);
    chk("after_reset recv_hazard", i_mem_recv_hazard, 1'b0);
    chk("after_reset pc_count", dut.pc_count, 0);
    chk("after_reset hold_count", dut.hold_count, 0);

    // Table: hazards evaluated before the edge, registered state after it.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      issue_valid = vecs[i].iv; issue_PC = vecs[i].ipc;
      i_mem_valid = vecs[i].mv; i_mem_data = vecs[i].md;
      stall_fetch_receive = vecs[i].st; flush_fetch_receive = vecs[i].fl;
      #1;
      chk($sformatf("v%0d issue_hazard", i), i_mem_issue_hazard, vecs[i].e_ih);
      chk($sformatf("v%0d recv_hazard", i), i_mem_recv_hazard, vecs[i].e_rh);
      @(posedge clock);
      #1;
      chk_out($sformatf("v%0d", i), vecs[i].e_inst, vecs[i].e_pc, vecs[i].e_v);
      chk($sformatf("v%0d pc_count", i), dut.pc_count, vecs[i].e_pcc);
      chk($sformatf("v%0d hold_count", i), dut.hold_count, vecs[i].e_hc);
    end

    // Reset asserted mid-stall with two held responses and a valid output.
    drive(1, 32'h500, 0, 0,            0, 0);
    drive(1, 32'h504, 1, 32'hD0D0D0D0, 0, 0);
    drive(1, 32'h508, 0, 0,            1, 0);
    drive(0, 0,       1, 32'hE1E1E1E1, 1, 0);
    drive(0, 0,       1, 32'hE2E2E2E2, 1, 0);
    chk_out("pre_rst", 32'hD0D0D0D0, 32'h500, 1'b1);
    chk("pre_rst hold_count", dut.hold_count, 2);
    chk("pre_rst issue_hazard", i_mem_issue_hazard, 1'b1);
    @(negedge clock);
    i_mem_valid = 0; issue_valid = 0;
    #2;
    reset = 1'b0;
    #1;
    chk_out("mid_rst", NOP_V, 0, 1'b0);
    chk("mid_rst pc_count", dut.pc_count, 0);
    chk("mid_rst hold_count", dut.hold_count, 0);
    chk("mid_rst issue_hazard", i_mem_issue_hazard, 1'b0);
    chk("mid_rst recv_hazard", i_mem_recv_hazard, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    stall_fetch_receive = 0;

    // Held responses must not replay after reset; normal operation resumes.
    drive(1, 32'h600, 0, 0,            0, 0);
    chk_out("post_rst idle", NOP_V, 0, 1'b0);
    chk("post_rst recv_hazard", i_mem_recv_hazard, 1'b1);
    drive(0, 0,       1, 32'h06000013, 0, 0);
    chk_out("post_rst resp", 32'h06000013, 32'h600, 1'b1);
    drive(0, 0,       0, 0,            0, 0);
    chk_out("post_rst drain", NOP_V, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
